// File: rtl/mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// mem_arbiter_pkg
// Shared definitions for the two-port memory arbiter: bus widths, the
// arbiter state encoding and the port identifiers.
//   RegBus     : width of the data bus (read and write data)
//   MemAddrBus : width of the memory address bus
//   ArbIdle / ArbBusy / ArbDone : 2-bit arbiter state encodings
//   PortIF  (0): instruction fetch port
//   PortMEM (1): MEM pipeline stage port
// ---------------------------------------------------------------------------
package mem_arbiter_pkg;

    localparam int RegBus     = 32;
    localparam int MemAddrBus = 32;

    typedef enum logic [1:0] {
        ArbIdle = 2'd0,
        ArbBusy = 2'd1,
        ArbDone = 2'd2
    } arb_state_e;

    localparam logic PortIF  = 1'b0;
    localparam logic PortMEM = 1'b1;

endpackage

// File: rtl/mem_arbiter_grant.sv
// ---------------------------------------------------------------------------
// mem_arbiter_grant
// Combinational grant picker for the two-port memory arbiter.
// Build option: MEM_ARB_RR_EN
//   undefined : fixed priority, the MEM port wins any tie
//   defined   : round-robin, a tie goes to the port that lost the last tie
// Ports:
//   req_i        : per-port request (bit 0 IF, bit 1 MEM)
//   last_grant_i : winner of the previous tie (MEM_ARB_RR_EN only)
//   valid_o      : at least one port is requesting
//   port_o       : selected port, meaningful only while valid_o is high
// ---------------------------------------------------------------------------
module mem_arbiter_grant
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
`ifdef MEM_ARB_RR_EN
    input  logic       last_grant_i,
`endif
    output logic       valid_o,
    output logic       port_o
);

    always_comb begin
        valid_o = |req_i;
        port_o  = PortIF;
        if (req_i == 2'b11) begin
`ifdef MEM_ARB_RR_EN
            port_o = ~last_grant_i;
`else
            // MEM drains first so the pipeline cannot deadlock on fetch
            port_o = PortMEM;
`endif
        end else if (req_i[1]) begin
            port_o = PortMEM;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares the single external memory port between instruction fetch (port 0)
// and the MEM stage (port 1). One request is latched at a time, the external
// req/ack handshake is driven, and per-port busy/done status plus the read
// data are returned.
// Build option: MEM_ARB_RR_EN selects round-robin tie breaking instead of
// fixed MEM-over-IF priority.
// Ports:
//   clk, rst                : clock (rising edge), async active-low reset
//   req_re, req_we          : per-port read/write request, held until done
//   req_addr0/1, req_sel0/1 : per-port address and byte lanes
//   req_wdata0/1            : per-port write data
//   flush                   : kill an in-flight IF transaction
//   ext_req/we/addr/sel/wdata : external memory cycle
//   ext_ack, ext_rdata      : external completion and read data
//   busy                    : port has a pending or in-flight request
//   done                    : one-cycle completion pulse per port
//   rdata                   : captured read data, valid while done is high
// ---------------------------------------------------------------------------
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            req_re,
    input  logic [1:0]            req_we,
    input  logic [MemAddrBus-1:0] req_addr0,
    input  logic [MemAddrBus-1:0] req_addr1,
    input  logic [3:0]            req_sel0,
    input  logic [3:0]            req_sel1,
    input  logic [RegBus-1:0]     req_wdata0,
    input  logic [RegBus-1:0]     req_wdata1,
    input  logic                  flush,
    output logic                  ext_req,
    output logic                  ext_we,
    output logic [MemAddrBus-1:0] ext_addr,
    output logic [3:0]            ext_sel,
    output logic [RegBus-1:0]     ext_wdata,
    input  logic                  ext_ack,
    input  logic [RegBus-1:0]     ext_rdata,
    output logic [1:0]            busy,
    output logic [1:0]            done,
    output logic [RegBus-1:0]     rdata
);

    arb_state_e            state_q, state_d;
    logic                  own_q, own_d;
    logic                  kill_q, kill_d;
    logic                  ext_req_q, ext_req_d;
    logic                  ext_we_q, ext_we_d;
    logic [MemAddrBus-1:0] ext_addr_q, ext_addr_d;
    logic [3:0]            ext_sel_q, ext_sel_d;
    logic [RegBus-1:0]     ext_wdata_q, ext_wdata_d;
    logic [RegBus-1:0]     rdata_q, rdata_d;
    logic [1:0]            req_any;
    logic                  grant_valid;
    logic                  grant_port;
`ifdef MEM_ARB_RR_EN
    logic                  last_grant_q, last_grant_d;
`endif

    assign req_any = req_re | req_we;

    mem_arbiter_grant u_grant (
        .req_i        (req_any),
`ifdef MEM_ARB_RR_EN
        .last_grant_i (last_grant_q),
`endif
        .valid_o      (grant_valid),
        .port_o       (grant_port)
    );

    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        kill_d      = kill_q;
        ext_req_d   = ext_req_q;
        ext_we_d    = ext_we_q;
        ext_addr_d  = ext_addr_q;
        ext_sel_d   = ext_sel_q;
        ext_wdata_d = ext_wdata_q;
        rdata_d     = rdata_q;
`ifdef MEM_ARB_RR_EN
        last_grant_d = last_grant_q;
`endif

        case (state_q)
            ArbIdle: begin
                if (grant_valid) begin
                    own_d     = grant_port;
                    kill_d    = 1'b0;
                    ext_req_d = 1'b1;
                    // a simultaneous re+we is a write because we is taken directly
                    ext_we_d  = req_we[grant_port];
                    if (grant_port == PortMEM) begin
                        ext_addr_d  = req_addr1;
                        ext_sel_d   = req_sel1;
                        ext_wdata_d = req_wdata1;
                    end else begin
                        ext_addr_d  = req_addr0;
                        ext_sel_d   = req_sel0;
                        ext_wdata_d = req_wdata0;
                    end
`ifdef MEM_ARB_RR_EN
                    // only contested grants move the round-robin pointer
                    if (req_any == 2'b11) begin
                        last_grant_d = grant_port;
                    end
`endif
                    state_d = ArbBusy;
                end
            end
            ArbBusy: begin
                // the external cycle cannot be aborted; a flushed fetch just
                // loses its completion pulse
                if (flush && (own_q == PortIF)) begin
                    kill_d = 1'b1;
                end
                if (ext_ack) begin
                    rdata_d   = ext_rdata;
                    ext_req_d = 1'b0;
                    state_d   = ArbDone;
                end
            end
            ArbDone: begin
                state_d = ArbIdle;
            end
            default: begin
                state_d = ArbIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ArbIdle;
            own_q       <= PortIF;
            kill_q      <= 1'b0;
            ext_req_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= '0;
            ext_sel_q   <= '0;
            ext_wdata_q <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            kill_q      <= kill_d;
            ext_req_q   <= ext_req_d;
            ext_we_q    <= ext_we_d;
            ext_addr_q  <= ext_addr_d;
            ext_sel_q   <= ext_sel_d;
            ext_wdata_q <= ext_wdata_d;
            rdata_q     <= rdata_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    // reset to IF so that MEM wins the first tie
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant_q <= PortIF;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_comb begin
        done = 2'b00;
        if (state_q == ArbDone) begin
            if (own_q == PortMEM) begin
                done[1] = 1'b1;
            end else if (!kill_q) begin
                done[0] = 1'b1;
            end
        end
    end

    assign busy      = req_any & ~done;
    assign ext_req   = ext_req_q;
    assign ext_we    = ext_we_q;
    assign ext_addr  = ext_addr_q;
    assign ext_sel   = ext_sel_q;
    assign ext_wdata = ext_wdata_q;
    assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter. Directed scenarios cover reset,
// single reads, ties, flush and back-to-back traffic; a randomized run acts
// as both requesters and the external memory and checks every cycle against
// a transaction-level model of the arbitration rules.
// Honours MEM_ARB_RR_EN when choosing the expected tie winner.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [1:0]            req_re = '0;
    logic [1:0]            req_we = '0;
    logic [MemAddrBus-1:0] req_addr0 = '0;
    logic [MemAddrBus-1:0] req_addr1 = '0;
    logic [3:0]            req_sel0 = '0;
    logic [3:0]            req_sel1 = '0;
    logic [RegBus-1:0]     req_wdata0 = '0;
    logic [RegBus-1:0]     req_wdata1 = '0;
    logic                  flush = 1'b0;
    logic                  ext_req;
    logic                  ext_we;
    logic [MemAddrBus-1:0] ext_addr;
    logic [3:0]            ext_sel;
    logic [RegBus-1:0]     ext_wdata;
    logic                  ext_ack = 1'b0;
    logic [RegBus-1:0]     ext_rdata = '0;
    logic [1:0]            busy;
    logic [1:0]            done;
    logic [RegBus-1:0]     rdata;

    int   testsRun    = 0;
    int   testsFailed = 0;
    // winner of the most recent tie, used only by the round-robin model
    logic modelLast   = 1'b0;

    mem_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .req_re     (req_re),
        .req_we     (req_we),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_sel0   (req_sel0),
        .req_sel1   (req_sel1),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .flush      (flush),
        .ext_req    (ext_req),
        .ext_we     (ext_we),
        .ext_addr   (ext_addr),
        .ext_sel    (ext_sel),
        .ext_wdata  (ext_wdata),
        .ext_ack    (ext_ack),
        .ext_rdata  (ext_rdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata)
    );

    always #5 clk = ~clk;

    // advance one cycle and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // expected winner among the ports requesting at an idle edge
    function automatic logic pickWinner(input logic [1:0] reqs);
        if (reqs == 2'b11) begin
`ifdef MEM_ARB_RR_EN
            return ~modelLast;
`else
            return 1'b1;
`endif
        end
        return reqs[1];
    endfunction

    task automatic test_reset();
        rst = 1'b0; req_re = '0; req_we = '0; ext_ack = 1'b0; flush = 1'b0;
        modelLast = 1'b0;
        tick(); tick();
        testsRun++;
        if ({ext_req, ext_we, ext_addr, ext_sel, ext_wdata, rdata, done, busy} !== '0) begin
            testsFailed++;
            $display("[TB] FAIL reset_values: ext_req=%b ext_we=%b addr=%h sel=%h wdata=%h rdata=%h done=%b busy=%b, all must be 0",
                     ext_req, ext_we, ext_addr, ext_sel, ext_wdata, rdata, done, busy);
        end
        rst = 1'b1;
        tick();
        req_re = 2'b10; req_addr1 = 32'h300; req_sel1 = 4'hF;
        tick();
        testsRun++;
        if (ext_req !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_pre_grant: ext_req=%b expected 1", ext_req);
        end
        #2 rst = 1'b0;
        #1;
        modelLast = 1'b0;
        testsRun++;
        if (ext_req !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_async_drop: ext_req=%b expected 0", ext_req);
        end
        req_re = 2'b00;
        #1;
        testsRun++;
        if (busy !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL reset_busy: busy=%b expected 00", busy);
        end
        tick();
        rst = 1'b1;
        tick();
        testsRun++;
        if (ext_req !== 1'b0 || done !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL reset_release: ext_req=%b done=%b expected 0/00", ext_req, done);
        end
        req_re = 2'b01; req_addr0 = 32'h44; req_sel0 = 4'h1;
        tick();
        testsRun++;
        if (ext_req !== 1'b1 || ext_addr !== 32'h44) begin
            testsFailed++;
            $display("[TB] FAIL reset_idle_grant: ext_req=%b addr=%h expected 1/00000044", ext_req, ext_addr);
        end
        ext_ack = 1'b1; ext_rdata = 32'h1;
        tick();
        ext_ack = 1'b0;
        testsRun++;
        if (done !== 2'b01) begin
            testsFailed++;
            $display("[TB] FAIL reset_first_done: done=%b expected 01", done);
        end
        req_re = 2'b00;
        tick();
    endtask

    task automatic test_mem_read();
        req_re = 2'b10; req_we = 2'b00; req_addr1 = 32'h100; req_sel1 = 4'hF;
        tick();
        testsRun++;
        if (ext_req !== 1'b1 || ext_we !== 1'b0 || ext_addr !== 32'h100 || ext_sel !== 4'hF) begin
            testsFailed++;
            $display("[TB] FAIL read_grant: req=%b we=%b addr=%h sel=%h expected 1/0/100/f",
                     ext_req, ext_we, ext_addr, ext_sel);
        end
        testsRun++;
        if (busy !== 2'b10 || done !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL read_busy: busy=%b done=%b expected 10/00", busy, done);
        end
        tick();
        testsRun++;
        if (ext_req !== 1'b1 || ext_addr !== 32'h100) begin
            testsFailed++;
            $display("[TB] FAIL read_stable: req=%b addr=%h expected 1/100", ext_req, ext_addr);
        end
        tick();
        ext_ack = 1'b1; ext_rdata = 32'hDEADBEEF;
        tick();
        ext_ack = 1'b0; ext_rdata = 32'h0;
        testsRun++;
        if (done !== 2'b10 || rdata !== 32'hDEADBEEF || ext_req !== 1'b0 || busy !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL read_done: done=%b rdata=%h req=%b busy=%b expected 10/deadbeef/0/00",
                     done, rdata, ext_req, busy);
        end
        req_re = 2'b00;
        tick();
        testsRun++;
        if (done !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL read_done_pulse: done=%b expected 00", done);
        end
    endtask

    task automatic test_tie();
        logic              w;
        logic              l;
        logic [1:0]        wBit;
        logic [1:0]        lBit;
        logic [RegBus-1:0] d;
        for (int rep = 0; rep < 2; rep++) begin
            req_addr0 = 32'h0;   req_sel0 = 4'hF; req_wdata0 = 32'h0;
            req_addr1 = 32'h200; req_sel1 = 4'h3; req_wdata1 = 32'h12345678;
            req_re = 2'b01; req_we = 2'b10;
            w = pickWinner(2'b11);
            modelLast = w;
            l = ~w;
            wBit = w ? 2'b10 : 2'b01;
            lBit = ~wBit;
            tick();
            testsRun++;
            if (ext_req !== 1'b1 || ext_we !== req_we[w] || ext_addr !== (w ? 32'h200 : 32'h0) ||
                ext_sel !== (w ? 4'h3 : 4'hF)) begin
                testsFailed++;
                $display("[TB] FAIL tie_first rep%0d: we=%b addr=%h sel=%h expected port %0d", rep, ext_we, ext_addr, ext_sel, w);
            end
            testsRun++;
            if (busy !== 2'b11) begin
                testsFailed++;
                $display("[TB] FAIL tie_busy rep%0d: busy=%b expected 11", rep, busy);
            end
            d = $urandom; ext_ack = 1'b1; ext_rdata = d;
            tick();
            ext_ack = 1'b0;
            testsRun++;
            if (done !== wBit || rdata !== d || busy !== lBit) begin
                testsFailed++;
                $display("[TB] FAIL tie_first_done rep%0d: done=%b rdata=%h busy=%b expected %b/%h/%b",
                         rep, done, rdata, busy, wBit, d, lBit);
            end
            if (w) req_we[1] = 1'b0; else req_re[0] = 1'b0;
            tick();
            testsRun++;
            if (done !== 2'b00 || ext_req !== 1'b0 || busy !== lBit) begin
                testsFailed++;
                $display("[TB] FAIL tie_gap rep%0d: done=%b req=%b busy=%b expected 00/0/%b", rep, done, ext_req, busy, lBit);
            end
            tick();
            testsRun++;
            if (ext_req !== 1'b1 || ext_we !== req_we[l] || ext_addr !== (l ? 32'h200 : 32'h0)) begin
                testsFailed++;
                $display("[TB] FAIL tie_second rep%0d: req=%b we=%b addr=%h expected port %0d", rep, ext_req, ext_we, ext_addr, l);
            end
            d = $urandom; ext_ack = 1'b1; ext_rdata = d;
            tick();
            ext_ack = 1'b0;
            testsRun++;
            if (done !== lBit || rdata !== d) begin
                testsFailed++;
                $display("[TB] FAIL tie_second_done rep%0d: done=%b rdata=%h expected %b/%h", rep, done, rdata, lBit, d);
            end
            req_re = 2'b00; req_we = 2'b00;
            tick();
        end
    endtask

    task automatic test_flush();
        req_re = 2'b01; req_we = 2'b00; req_addr0 = 32'h40; req_sel0 = 4'hF;
        tick();
        testsRun++;
        if (ext_req !== 1'b1 || ext_addr !== 32'h40) begin
            testsFailed++;
            $display("[TB] FAIL flush_grant: req=%b addr=%h expected 1/40", ext_req, ext_addr);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        testsRun++;
        if (ext_req !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL flush_not_aborted: ext_req=%b expected 1", ext_req);
        end
        ext_ack = 1'b1; ext_rdata = 32'hCAFEF00D;
        tick();
        ext_ack = 1'b0;
        testsRun++;
        if (done !== 2'b00 || ext_req !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL flush_suppressed: done=%b ext_req=%b expected 00/0", done, ext_req);
        end
        req_re = 2'b00;
        tick();
        // stray acks and flushes while idle must be ignored
        ext_ack = 1'b1; flush = 1'b1;
        tick(); tick();
        testsRun++;
        if (ext_req !== 1'b0 || done !== 2'b00) begin
            testsFailed++;
            $display("[TB] FAIL idle_ack_ignored: ext_req=%b done=%b expected 0/00", ext_req, done);
        end
        ext_ack = 1'b0; flush = 1'b0;
        req_re = 2'b10; req_addr1 = 32'h80; req_sel1 = 4'hC;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; ext_ack = 1'b1; ext_rdata = 32'h5A5A0001;
        tick();
        ext_ack = 1'b0;
        testsRun++;
        if (done !== 2'b10 || rdata !== 32'h5A5A0001) begin
            testsFailed++;
            $display("[TB] FAIL flush_mem_no_effect: done=%b rdata=%h expected 10/5a5a0001", done, rdata);
        end
        req_re = 2'b00;
        tick();
        req_re = 2'b01; req_addr0 = 32'h48;
        tick();
        ext_ack = 1'b1; ext_rdata = 32'h77;
        tick();
        ext_ack = 1'b0;
        testsRun++;
        if (done !== 2'b01 || rdata !== 32'h77) begin
            testsFailed++;
            $display("[TB] FAIL flush_kill_cleared: done=%b rdata=%h expected 01/77", done, rdata);
        end
        req_re = 2'b00;
        tick();
    endtask

    task automatic test_back_to_back();
        int                    lastRise = -1;
        int                    grants   = 0;
        logic                  prevReq  = 1'b0;
        logic                  ackPrev  = 1'b0;
        logic [MemAddrBus-1:0] a        = 32'h1000;
        logic [RegBus-1:0]     expData  = '0;
        req_re = 2'b10; req_we = 2'b00; req_addr1 = a; req_sel1 = 4'hF;
        for (int c = 0; c < 30; c++) begin
            tick();
            if (ext_req && !prevReq) begin
                grants++;
                if (lastRise >= 0) begin
                    testsRun++;
                    if (c - lastRise != 3) begin
                        testsFailed++;
                        $display("[TB] FAIL b2b_spacing: %0d cycles between grants, expected 3", c - lastRise);
                    end
                end
                lastRise = c;
            end
            if (ext_req) begin
                testsRun++;
                if (ext_addr !== a || ext_we !== 1'b0 || ext_sel !== 4'hF) begin
                    testsFailed++;
                    $display("[TB] FAIL b2b_stable: addr=%h we=%b sel=%h expected %h/0/f", ext_addr, ext_we, ext_sel, a);
                end
            end
            testsRun++;
            if (done !== (ackPrev ? 2'b10 : 2'b00) || (ackPrev && rdata !== expData)) begin
                testsFailed++;
                $display("[TB] FAIL b2b_done: done=%b rdata=%h expected %b/%h", done, rdata, ackPrev ? 2'b10 : 2'b00, expData);
            end
            prevReq = ext_req;
            if (ackPrev) begin
                req_re = 2'b00;
                a = a + 32'h4;
                req_addr1 = a;
            end else begin
                req_re = 2'b10;
            end
            ackPrev = ext_req;
            expData = {a[15:0], 16'hBEEF};
            ext_ack = ext_req;
            ext_rdata = expData;
        end
        testsRun++;
        if (grants != 10) begin
            testsFailed++;
            $display("[TB] FAIL b2b_count: %0d grants in 30 cycles, expected 10", grants);
        end
        req_re = 2'b00; ext_ack = 1'b0;
        tick(); tick();
    endtask

    task automatic test_random();
        logic                  txActive  = 1'b0;
        logic                  cooldown  = 1'b0;
        logic                  ackDriven = 1'b0;
        logic                  win       = 1'b0;
        logic [1:0]            reqAtEdge;
        logic [1:0]            expDone;
        logic [1:0]            justDropped;
        logic [RegBus-1:0]     ackData   = '0;
        int                    ackDelay  = 0;
        int                    completed = 0;
        int                    kind;
        logic                  gWe       = 1'b0;
        logic [MemAddrBus-1:0] gAddr     = '0;
        logic [3:0]            gSel      = '0;
        logic [RegBus-1:0]     gWdata    = '0;
        req_re = '0; req_we = '0; ext_ack = 1'b0; flush = 1'b0;
        for (int c = 0; c < 400; c++) begin
            reqAtEdge = req_re | req_we;
            tick();
            justDropped = 2'b00;
            expDone = (txActive && ackDriven) ? (win ? 2'b10 : 2'b01) : 2'b00;
            testsRun++;
            if (done !== expDone) begin
                testsFailed++;
                $display("[TB] FAIL rand_done c%0d: done=%b expected %b", c, done, expDone);
            end
            testsRun++;
            if (busy !== ((req_re | req_we) & ~expDone)) begin
                testsFailed++;
                $display("[TB] FAIL rand_busy c%0d: busy=%b expected %b", c, busy, (req_re | req_we) & ~expDone);
            end
            if (txActive && ackDriven) begin
                testsRun++;
                if (rdata !== ackData || ext_req !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL rand_complete c%0d: rdata=%h ext_req=%b expected %h/0", c, rdata, ext_req, ackData);
                end
                txActive = 1'b0; cooldown = 1'b1; ackDriven = 1'b0; completed++;
                req_re[win] = 1'b0; req_we[win] = 1'b0;
                justDropped[win] = 1'b1;
            end else if (txActive) begin
                testsRun++;
                if (ext_req !== 1'b1 || ext_we !== gWe || ext_addr !== gAddr || ext_sel !== gSel || ext_wdata !== gWdata) begin
                    testsFailed++;
                    $display("[TB] FAIL rand_hold c%0d: req=%b we=%b addr=%h sel=%h wdata=%h expected 1/%b/%h/%h/%h",
                             c, ext_req, ext_we, ext_addr, ext_sel, ext_wdata, gWe, gAddr, gSel, gWdata);
                end
            end else if (cooldown) begin
                testsRun++;
                if (ext_req !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL rand_done_ignores c%0d: ext_req=%b expected 0", c, ext_req);
                end
                cooldown = 1'b0;
            end else if (reqAtEdge != 2'b00) begin
                win = pickWinner(reqAtEdge);
                if (reqAtEdge == 2'b11) modelLast = win;
                gWe    = req_we[win];
                gAddr  = win ? req_addr1 : req_addr0;
                gSel   = win ? req_sel1 : req_sel0;
                gWdata = win ? req_wdata1 : req_wdata0;
                txActive = 1'b1;
                ackDelay = $urandom_range(0, 3);
                testsRun++;
                if (ext_req !== 1'b1 || ext_we !== gWe || ext_addr !== gAddr || ext_sel !== gSel || ext_wdata !== gWdata) begin
                    testsFailed++;
                    $display("[TB] FAIL rand_grant c%0d: req=%b we=%b addr=%h sel=%h wdata=%h expected port %0d 1/%b/%h/%h/%h",
                             c, ext_req, ext_we, ext_addr, ext_sel, ext_wdata, win, gWe, gAddr, gSel, gWdata);
                end
            end else begin
                testsRun++;
                if (ext_req !== 1'b0) begin
                    testsFailed++;
                    $display("[TB] FAIL rand_idle c%0d: ext_req=%b expected 0", c, ext_req);
                end
            end
            // external memory: ack after a random delay, noise acks otherwise
            if (txActive) begin
                if (ackDelay == 0) begin
                    ackData = $urandom;
                    ext_ack = 1'b1; ext_rdata = ackData; ackDriven = 1'b1;
                end else begin
                    ackDelay--;
                    ext_ack = 1'b0; ext_rdata = $urandom;
                end
            end else begin
                ext_ack = ($urandom_range(0, 3) == 0); ext_rdata = $urandom;
            end
            // requesters: start new requests only on idle ports
            for (int p = 0; p < 2; p++) begin
                if (!(req_re[p] | req_we[p]) && !justDropped[p] && $urandom_range(0, 2) == 0) begin
                    kind = $urandom_range(0, 2);
                    req_re[p] = (kind != 1);
                    req_we[p] = (kind != 0);
                    if (p == 1) begin
                        req_addr1 = $urandom; req_sel1 = 4'($urandom); req_wdata1 = $urandom;
                    end else begin
                        req_addr0 = $urandom; req_sel0 = 4'($urandom); req_wdata0 = $urandom;
                    end
                end
            end
        end
        testsRun++;
        if (completed < 20) begin
            testsFailed++;
            $display("[TB] FAIL rand_progress: %0d transactions completed, expected at least 20", completed);
        end
        req_re = '0; req_we = '0; ext_ack = 1'b0;
        tick(); tick(); tick();
    endtask

    initial begin
        test_reset();
        test_mem_read();
        test_tie();
        test_flush();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory bus arbiter sharing the single external memory port between instruction fetch (port 0) and the MEM pipeline stage (port 1). It latches one request at a time, drives the external request/acknowledge handshake, and returns per-port `busy`/`done` status plus read data. Its 2-bit status vectors connect directly to `stage_mem`'s `mem_busy`/`mem_done` inputs and to the fetch stage, with bit 0 for IF and bit 1 for MEM.

## Interface
- No parameters; widths come from `RegBus` and `MemAddrBus` in `defines.v`.
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-low reset; `rst==0` resets.
- `req_re` in 2: per-port read request, level held until `done`.
- `req_we` in 2: per-port write request, level held until `done`.
- `req_addr0`, `req_addr1` in `MemAddrBus`: per-port address.
- `req_sel0`, `req_sel1` in 4: per-port byte lanes.
- `req_wdata0`, `req_wdata1` in `RegBus`: per-port write data.
- `flush` in 1: kill the IF transaction (port 0 only).
- `ext_req` out 1: external cycle valid.
- `ext_we` out 1: external write.
- `ext_addr` out `MemAddrBus`: external address.
- `ext_sel` out 4: external byte lanes.
- `ext_wdata` out `RegBus`: external write data.
- `ext_ack` in 1: external cycle complete; read data valid this cycle.
- `ext_rdata` in `RegBus`: external read data.
- `busy` out 2: port i has a pending or in-flight request.
- `done` out 2: one-cycle completion pulse per port.
- `rdata` out `RegBus`: captured read data, valid while `done` is high.

## Operation
- FSM states: IDLE, BUSY, DONE. Owner register `own` is 1 bit.
- Port i is requesting when `req_re[i] | req_we[i]` is high.
- IDLE:
  - With no request, stay in IDLE.
  - Otherwise grant one port. Latch its addr, sel, wdata and `we=req_we[i]` into the `ext_*` registers, set `own`, then go to BUSY.
  - Fixed priority: port 1 (MEM) wins over port 0. Port 1 draining first avoids a pipeline deadlock.
- BUSY:
  - `ext_req` stays 1. `ext_*` outputs stay stable until ack.
  - On `ext_ack`: capture `ext_rdata` into `rdata` (writes capture it too), drop `ext_req`, and go to DONE.
- DONE:
  - Lasts exactly one cycle. `done[own]` is 1 and requests are ignored.
  - Next state is IDLE. The requester must drop its request in the same cycle it sees `done`.
- `busy[i] = req_i & ~done[i]`. This is combinational from the request and the registered state.
- `flush` while `own==0` in BUSY:
  - The external cycle cannot be aborted. It completes normally.
  - A kill flag is set. In DONE, `done[0]` is suppressed.
- `flush` while IDLE or while `own==1`: no effect.
- Both `req_re[i]` and `req_we[i]` high: treated as a write.

## Timing
- Reset values: `ext_req`, `ext_we` = 0; `ext_addr`, `ext_sel`, `ext_wdata`, `rdata` = 0; `done` = 0; state IDLE; kill flag 0.
- An asynchronous reset during BUSY drops `ext_req` immediately. The external side must tolerate the abandoned cycle.
- Request seen in IDLE at cycle N: `ext_req` is high from N+1.
- `ext_ack` at cycle M: `done` and `rdata` at M+1, IDLE at M+2.
- Minimum latency, with ack on the first BUSY cycle: request to `done` is 2 cycles. Back-to-back transactions take 3 cycles each.
- `ext_ack` is ignored outside BUSY.

## Configuration
- `MEM_ARB_RR_EN` defined:
  - Round-robin grant. On a simultaneous request, the port that was not granted last wins.
  - A last-grant flop is added, reset to 0, so port 1 wins the first tie.
- `MEM_ARB_RR_EN` undefined: fixed priority, port 1 over port 0.

## Structure
- Add to `defines.v`: `ArbIdle`/`ArbBusy`/`ArbDone` state encodings (2 bits), plus `PortIF` = 0 and `PortMEM` = 1.
- One sub-module is natural: `arb_grant`, a combinational grant picker with the `MEM_ARB_RR_EN` option inside.

## Test plan
- Reset mid-BUSY (`own=1`, `ext_req=1`), `rst` low -> `ext_req` = 0 immediately, `busy` = 0 once requests drop, IDLE after release.
- Port 1 read, addr 0x100, sel 0xF, ack 2 cycles after `ext_req` -> `ext_we=0`, `ext_addr=0x100`, `done=2'b10` one cycle after ack, `rdata=ext_rdata` (0xDEADBEEF).
- Simultaneous port 0 read 0x0 and port 1 write 0x200/0x12345678, sel 0x3 -> port 1 is served first (`ext_we=1`, `ext_sel=0x3`), then port 0. `busy[0]=1` throughout; `done` goes 2'b10 then 2'b01.
- Same stimulus with `MEM_ARB_RR_EN`, repeated twice -> second tie is granted to port 0.
- Port 0 read in BUSY with `flush` pulsed -> external cycle still acked, `done[0]` stays 0, arbiter returns to IDLE.
- Continuous port 1 requests with ack in the same cycle as `ext_req` -> one transaction every 3 cycles, `ext_*` stable during each BUSY.
